// File: rtl/alu_pkg.sv
// alu_pkg: opcode type and alucont encodings shared by the ALU and its testbench.
package alu_pkg;
  typedef logic [2:0] alu_op_t;
  localparam alu_op_t ALU_AND  = 3'b000;
  localparam alu_op_t ALU_OR   = 3'b001;
  localparam alu_op_t ALU_ADD  = 3'b010;
  localparam alu_op_t ALU_ANDN = 3'b100;
  localparam alu_op_t ALU_ORN  = 3'b101;
  localparam alu_op_t ALU_SUB  = 3'b110;
  localparam alu_op_t ALU_SLT  = 3'b111;
endpackage

// File: rtl/alu_adder.sv
// alu_adder: DATA_WIDTH adder with carry-in, producing the wrapped sum and signed overflow.
module alu_adder
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  v
);
  assign sum = a + b + {{(DATA_WIDTH-1){1'b0}}, cin};
  assign v   = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
endmodule

// File: rtl/alu.sv
// alu: AND/OR/ADD/SUB/SLT execute-stage ALU with zero flag and registered copies.
// Define ALU_OVERFLOW_EN to add the ovf/ovf_q signed-overflow outputs.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_op_t               alucont,
  output logic                  zero,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_q,
  output logic                  zero_q
`ifdef ALU_OVERFLOW_EN
  ,
  output logic                  ovf,
  output logic                  ovf_q
`endif
);
  logic [DATA_WIDTH-1:0] bb, sum;
  logic                  v, lt;
  assign bb = alucont[2] ? ~b : b;
  alu_adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
    .a(a), .b(bb), .cin(alucont[2]), .sum(sum), .v(v)
  );
  // sign of the wrapped sum corrected by overflow gives a true signed compare
  assign lt = sum[DATA_WIDTH-1] ^ v;
  always_comb
    result = alucont[1:0] == ALU_AND[1:0] ? a & bb :
             alucont[1:0] == ALU_OR[1:0]  ? a | bb :
             alucont[1:0] == ALU_ADD[1:0] ? sum :
                                            {{(DATA_WIDTH-1){1'b0}}, lt};
  assign zero = result == '0;
`ifdef ALU_OVERFLOW_EN
  assign ovf = (alucont[1:0] == ALU_ADD[1:0]) && v;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
`ifdef ALU_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      result_q <= result;
      zero_q   <= zero;
`ifdef ALU_OVERFLOW_EN
      ovf_q    <= ovf;
`endif
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu; stimulus queues expectations, a negedge monitor checks them.
module tb_alu;
  import alu_pkg::*;
  localparam int W = 32;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  alu_op_t      alucont = ALU_AND;
  logic         zero, zero_q;
  logic [W-1:0] result, result_q;
`ifdef ALU_OVERFLOW_EN
  logic         ovf, ovf_q;
`endif
  always #5 clk = ~clk;
  alu #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .alucont(alucont),
    .zero(zero), .result(result), .result_q(result_q), .zero_q(zero_q)
`ifdef ALU_OVERFLOW_EN
    , .ovf(ovf), .ovf_q(ovf_q)
`endif
  );
  typedef struct {
    string        name;
    bit           regd;
    logic [W-1:0] r;
    logic         z;
    logic         o;
  } exp_t;
  typedef struct {
    string        name;
    alu_op_t      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         z;
    logic         o;
  } vec_t;
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  vec_t vt[14] = '{
    '{"and",      ALU_AND,  32'h01234567, 32'h76543210, 32'h00000000, 1'b1, 1'b0},
    '{"or",       ALU_OR,   32'h01234567, 32'h76543210, 32'h77777777, 1'b0, 1'b0},
    '{"andn",     ALU_ANDN, 32'h01234567, 32'h76543210, 32'h01234567, 1'b0, 1'b0},
    '{"orn",      ALU_ORN,  32'h01234567, 32'h76543210, 32'h89abcdef, 1'b0, 1'b0},
    '{"add",      ALU_ADD,  32'h01234567, 32'h76543210, 32'h77777777, 1'b0, 1'b0},
    '{"sub",      ALU_SUB,  32'h01234567, 32'h76543210, 32'h8acf1357, 1'b0, 1'b0},
    '{"slt",      ALU_SLT,  32'h01234567, 32'h76543210, 32'h00000001, 1'b0, 1'b0},
    '{"sub_eq",   ALU_SUB,  32'h01234567, 32'h01234567, 32'h00000000, 1'b1, 1'b0},
    '{"slt_ovf",  ALU_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
    '{"slt_swap", ALU_SLT,  32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0},
    '{"add_ovf",  ALU_ADD,  32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b1},
    '{"sub_ovf",  ALU_SUB,  32'h80000000, 32'h00000001, 32'h7fffffff, 1'b0, 1'b1},
    '{"rsv_nov",  3'b011,   32'h01234567, 32'h76543210, 32'h00000000, 1'b1, 1'b0},
    '{"rsv_ovf",  3'b011,   32'h80000000, 32'h80000000, 32'h00000001, 1'b0, 1'b0}
  };
  task automatic push(input string n, input bit regd, input logic [W-1:0] r, input logic z, input logic o);
    sb.push_back('{n, regd, r, z, o});
  endtask
  task automatic drive(input alu_op_t op, input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(posedge clk);
    #1;
    a = aa;
    b = bb;
    alucont = op;
  endtask
  always @(negedge clk)
    while (sb.size() > 0) begin
      exp_t         e;
      logic [W-1:0] ar;
      logic         az;
      e  = sb.pop_front();
      ar = e.regd ? result_q : result;
      az = e.regd ? zero_q : zero;
      n_chk++;
      if (ar !== e.r) begin
        n_fail++;
        $display("FAIL %s%s result: got %h expected %h", e.name, e.regd ? "_q" : "", ar, e.r);
      end
      n_chk++;
      if (az !== e.z) begin
        n_fail++;
        $display("FAIL %s%s zero: got %b expected %b", e.name, e.regd ? "_q" : "", az, e.z);
      end
`ifdef ALU_OVERFLOW_EN
      n_chk++;
      if ((e.regd ? ovf_q : ovf) !== e.o) begin
        n_fail++;
        $display("FAIL %s%s ovf: got %b expected %b", e.name, e.regd ? "_q" : "", e.regd ? ovf_q : ovf, e.o);
      end
`endif
    end
  initial begin
    // registers must hold reset values while reset is held across edges
    repeat (2) @(posedge clk);
    #1;
    push("rst_init", 1'b1, '0, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].op, vt[i].a, vt[i].b);
      if (i == 0) begin
        reset = 1'b0;
        push("rst_rel", 1'b1, '0, 1'b1, 1'b0);
      end else
        push(vt[i-1].name, 1'b1, vt[i-1].r, vt[i-1].z, vt[i-1].o);
      push(vt[i].name, 1'b0, vt[i].r, vt[i].z, vt[i].o);
    end
    // park on a nonzero result so reset is seen clearing live register state
    drive(ALU_ADD, 32'h7fffffff, 32'h00000001);
    push(vt[13].name, 1'b1, vt[13].r, vt[13].z, vt[13].o);
    push("pre_rst", 1'b0, 32'h80000000, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    push("async_rst", 1'b1, '0, 1'b1, 1'b0);
    push("rst_comb", 1'b0, 32'h80000000, 1'b0, 1'b1);
    drive(ALU_OR, 32'h01234567, 32'h76543210);
    push("rst_hold", 1'b1, '0, 1'b1, 1'b0);
    push("rst_track", 1'b0, 32'h77777777, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    drive(ALU_SUB, 32'h01234567, 32'h01234567);
    push("post_rst", 1'b1, 32'h77777777, 1'b0, 1'b0);
    push("post_rst_sub", 1'b0, 32'h00000000, 1'b1, 1'b0);
    drive(ALU_AND, 32'h01234567, 32'h76543210);
    push("sub_eq_reg", 1'b1, 32'h00000000, 1'b1, 1'b0);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
